// File: rtl/regbus_arbiter_if.sv
// regbus_arbiter_if: requester handshake and register-manager bus bundle.
//   req_valid/req_ready    per-requester request handshake (one-hot ready)
//   req_write/req_admin    per-requester command qualifiers
//   req_addr/req_wdata     packed per-requester address / write data
//   rsp_valid/rsp_rdata    one-hot completion pulse with read data
//   rsp_error, busy        write-timeout flag, arbiter-not-idle status
//   address..writeAdmin    bus outputs towards the register manager
//   readData, writeAck     bus inputs from the register manager
// Modport master is the arbiter side, slave is the requester/register side.
interface regbus_arbiter_if #(
    parameter int NUM_REQ     = 2,
    parameter int DATA_LENGTH = 32,
    parameter int ADDRWIDTH   = 8
);
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ-1:0]             req_write;
    logic [NUM_REQ-1:0]             req_admin;
    logic [NUM_REQ*ADDRWIDTH-1:0]   req_addr;
    logic [NUM_REQ*DATA_LENGTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]             rsp_valid;
    logic [DATA_LENGTH-1:0]         rsp_rdata;
    logic                           rsp_error;
    logic                           busy;
    logic [ADDRWIDTH-1:0]           address;
    logic [DATA_LENGTH-1:0]         writeData;
    logic                           writeEnable;
    logic                           readEnable;
    logic                           writeAdmin;
    logic [DATA_LENGTH-1:0]         readData;
    logic                           writeAck;

    modport master (
        input  req_valid, req_write, req_admin, req_addr, req_wdata, readData, writeAck,
        output req_ready, rsp_valid, rsp_rdata, rsp_error, busy,
               address, writeData, writeEnable, readEnable, writeAdmin
    );

    modport slave (
        output req_valid, req_write, req_admin, req_addr, req_wdata, readData, writeAck,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error, busy,
               address, writeData, writeEnable, readEnable, writeAdmin
    );
endinterface

// File: rtl/regbus_arbiter.sv
// regbus_arbiter: round-robin arbiter sharing one register-manager bus
// between NUM_REQ requesters, one transaction at a time.
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    regbus_arbiter_if.master: requester handshake, responses, bus
// Flow: IDLE grants (req_ready combinational), ISSUE drives a one-cycle
// strobe, WAIT collects writeAck / readData or times out, DONE pulses rsp_valid.
module regbus_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int DATA_LENGTH    = 32,
    parameter int ADDRWIDTH      = 8,
    parameter int READ_LATENCY   = 1,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic            clk,
    input logic            reset,
    regbus_arbiter_if.master bus
);
    localparam int unsigned PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CMAX = (TIMEOUT_CYCLES > READ_LATENCY) ? TIMEOUT_CYCLES : READ_LATENCY;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t               state;
    logic [PW-1:0]        ptr;
    logic [PW-1:0]        sel_q;
    logic [PW-1:0]        sel_c;
    logic [PW-1:0]        idx;
    logic                 grant;
    logic                 is_write;
    logic                 ack_seen;
    logic [CW-1:0]        cnt;
    logic [ADDRWIDTH-1:0]   addr_arr  [NUM_REQ];
    logic [DATA_LENGTH-1:0] wdata_arr [NUM_REQ];

    // First active requester at or above the pointer, wrapping around.
    always_comb begin
        grant = 1'b0;
        sel_c = '0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = PW'((32'(ptr) + i) % NUM_REQ);
            if (!grant && bus.req_valid[idx]) begin
                grant = 1'b1;
                sel_c = idx;
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            addr_arr[i]  = bus.req_addr[i*ADDRWIDTH +: ADDRWIDTH];
            wdata_arr[i] = bus.req_wdata[i*DATA_LENGTH +: DATA_LENGTH];
        end
    end

    // Ready is suppressed during reset so no command is handed over and dropped.
    always_comb begin
        bus.req_ready = '0;
        if (state == S_IDLE && grant && !reset) begin
            bus.req_ready[sel_c] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            ptr             <= '0;
            sel_q           <= '0;
            is_write        <= 1'b0;
            ack_seen        <= 1'b0;
            cnt             <= '0;
            bus.rsp_valid   <= '0;
            bus.rsp_rdata   <= '0;
            bus.rsp_error   <= 1'b0;
            bus.busy        <= 1'b0;
            bus.address     <= '0;
            bus.writeData   <= '0;
            bus.writeEnable <= 1'b0;
            bus.readEnable  <= 1'b0;
            bus.writeAdmin  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant) begin
                        sel_q           <= sel_c;
                        is_write        <= bus.req_write[sel_c];
                        bus.address     <= addr_arr[sel_c];
                        bus.writeData   <= wdata_arr[sel_c];
                        bus.writeAdmin  <= bus.req_admin[sel_c];
                        bus.writeEnable <= bus.req_write[sel_c];
                        bus.readEnable  <= !bus.req_write[sel_c];
                        bus.busy        <= 1'b1;
                        state           <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    bus.writeEnable <= 1'b0;
                    bus.readEnable  <= 1'b0;
                    cnt             <= '0;
                    // An ack arriving with the strobe is remembered for WAIT.
                    ack_seen        <= is_write & bus.writeAck;
                    state           <= S_WAIT;
                end
                S_WAIT: begin
                    if (is_write) begin
                        if (bus.writeAck || ack_seen) begin
                            bus.rsp_valid <= NUM_REQ'(1) << sel_q;
                            bus.rsp_error <= 1'b0;
                            bus.rsp_rdata <= '0;
                            state         <= S_DONE;
                        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                            bus.rsp_valid <= NUM_REQ'(1) << sel_q;
                            bus.rsp_error <= 1'b1;
                            bus.rsp_rdata <= '0;
                            state         <= S_DONE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        // First WAIT cycle is one cycle after ISSUE.
                        if (cnt == CW'(READ_LATENCY - 1)) begin
                            bus.rsp_valid <= NUM_REQ'(1) << sel_q;
                            bus.rsp_error <= 1'b0;
                            bus.rsp_rdata <= bus.readData;
                            state         <= S_DONE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    bus.rsp_valid  <= '0;
                    bus.rsp_rdata  <= '0;
                    bus.rsp_error  <= 1'b0;
                    bus.writeAdmin <= 1'b0;
                    bus.busy       <= 1'b0;
                    ptr            <= (32'(sel_q) == NUM_REQ - 1) ? '0 : sel_q + 1'b1;
                    state          <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_regbus_arbiter.sv
// tb_regbus_arbiter: self-checking bench for regbus_arbiter.
// Table-driven directed transactions, hand-written reset / contention
// sequences, and randomized transactions checked against a transaction-level
// model of the arbitration and timing rules.
module tb_regbus_arbiter;
    localparam int NR = 2;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int RL = 1;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    regbus_arbiter_if #(.NUM_REQ(NR), .DATA_LENGTH(DW), .ADDRWIDTH(AW)) bus ();

    regbus_arbiter #(
        .NUM_REQ(NR), .DATA_LENGTH(DW), .ADDRWIDTH(AW),
        .READ_LATENCY(RL), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.master)
    );

    typedef struct {
        logic [NR-1:0] mask;
        int            id;
        bit            w;
        bit            adm;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        int            d;      // ack cycle offset from ISSUE, -1 = never
        logic [DW-1:0] rd;
        int            lat;    // rsp_valid cycle relative to grant
        bit            err;
        logic [DW-1:0] exp_rd;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input bit w, input bit adm,
                           input logic [AW-1:0] a, input logic [DW-1:0] wd);
        bus.req_write[i]          = w;
        bus.req_admin[i]          = adm;
        bus.req_addr[i*AW +: AW]  = a;
        bus.req_wdata[i*DW +: DW] = wd;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ctrl"}, {bus.req_ready, bus.rsp_valid, bus.rsp_error, bus.busy,
                               bus.writeEnable, bus.readEnable, bus.writeAdmin}, 64'd0);
        check({tag, " rdata"}, bus.rsp_rdata, 64'd0);
        check({tag, " addr"}, bus.address, 64'd0);
        check({tag, " wdata"}, bus.writeData, 64'd0);
    endtask

    function automatic int onehot_idx(input logic [NR-1:0] v);
        int r = -1;
        for (int i = 0; i < NR; i++) if (v == NR'(1) << i) r = i;
        return r;
    endfunction

    // Reference timing: grant T, strobe T+1, first WAIT T+2.
    function automatic int model_lat(input bit w, input int d);
        if (!w) return 2 + RL;
        if (d < 0 || d > TO) return 2 + TO;
        return (d == 0) ? 3 : 2 + d;
    endfunction

    function automatic bit model_err(input bit w, input int d);
        return w && !(d >= 0 && d <= TO);
    endfunction

    // One transaction from grant through the following idle cycles.
    task automatic txn(input string tag, input logic [NR-1:0] mask, input int id,
                       input bit w, input bit adm, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input int d, input logic [DW-1:0] rd,
                       input int lat, input bit err, input logic [DW-1:0] exp_rd);
        int            strobe_c = -1;
        int            n_strobe = 0;
        int            rsp_c = -1;
        int            n_rsp = 0;
        bit            hold_ok = 1'b1;
        bit            busy_ok = 1'b1;
        bit            adm_ok = 1'b1;
        bit            kind_ok = 1'b1;
        logic [NR-1:0] rv = '0;
        logic [DW-1:0] got_rd = '0;
        logic          got_err = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = mask;
        bus.writeAck  = 1'b0;
        #4;
        check({tag, " grant"}, bus.req_ready, 64'(1) << id);
        for (int c = 1; c <= TO + 5; c++) begin
            @(posedge clk); #1;
            bus.req_valid = '0;
            bus.writeAck  = (c == 1 + d);
            bus.readData  = (c == 1 + RL) ? rd : DW'($urandom);
            #4;
            if (bus.writeEnable || bus.readEnable) begin
                n_strobe++;
                if (strobe_c < 0) strobe_c = c;
                if (bus.writeEnable !== w || bus.readEnable !== !w) kind_ok = 1'b0;
            end
            if (bus.address !== a || bus.writeData !== wd) hold_ok = 1'b0;
            if (bus.busy !== (c <= lat)) busy_ok = 1'b0;
            if (bus.writeAdmin !== ((c <= lat) && adm)) adm_ok = 1'b0;
            if (bus.rsp_valid !== '0) begin
                n_rsp++;
                if (rsp_c < 0) begin
                    rsp_c   = c;
                    rv      = bus.rsp_valid;
                    got_rd  = bus.rsp_rdata;
                    got_err = bus.rsp_error;
                end
            end
        end
        check({tag, " strobe count"}, n_strobe, 1);
        check({tag, " strobe cycle"}, strobe_c, 1);
        check({tag, " strobe kind"}, kind_ok, 1);
        check({tag, " bus hold"}, hold_ok, 1);
        check({tag, " busy"}, busy_ok, 1);
        check({tag, " writeAdmin"}, adm_ok, 1);
        check({tag, " rsp cycle"}, rsp_c, lat);
        check({tag, " rsp count"}, n_rsp, 1);
        check({tag, " rsp_valid"}, rv, 64'(1) << id);
        check({tag, " rsp_error"}, got_err, err);
        check({tag, " rsp_rdata"}, got_rd, exp_rd);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            g_ids[$];
        int            g_cyc[$];
        int            r_ids[$];
        int            we_n;
        bit            ovl;
        bit            seen;
        int            gs;
        int            rs;
        int            mptr;

        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_admin = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.readData  = '0;
        bus.writeAck  = 1'b0;

        // a: test-plan write, b: test-plan read, c: timeout, d: admin + ack in ISSUE,
        // e: read with stray ack, f: ack on last WAIT cycle, g: ack one cycle too late,
        // h: admin write with mid-range ack delay.
        tbl[0] = '{2'b01, 0, 1'b1, 1'b0, 8'h12, 32'hDEADBEEF, 1,  32'h0,        3,  1'b0, 32'h0};
        tbl[1] = '{2'b10, 1, 1'b0, 1'b0, 8'h05, 32'h0BAD0BAD, -1, 32'hCAFE0001, 3,  1'b0, 32'hCAFE0001};
        tbl[2] = '{2'b01, 0, 1'b1, 1'b0, 8'h21, 32'h00000055, -1, 32'h0,        18, 1'b1, 32'h0};
        tbl[3] = '{2'b11, 1, 1'b1, 1'b1, 8'h3C, 32'h01234567, 0,  32'h0,        3,  1'b0, 32'h0};
        tbl[4] = '{2'b11, 0, 1'b0, 1'b0, 8'hA0, 32'h0F0F0F0F, 1,  32'h5A5A5A5A, 3,  1'b0, 32'h5A5A5A5A};
        tbl[5] = '{2'b11, 1, 1'b1, 1'b0, 8'h66, 32'hFFFF0000, 16, 32'h0,        18, 1'b0, 32'h0};
        tbl[6] = '{2'b10, 1, 1'b1, 1'b0, 8'h67, 32'h12345678, 17, 32'h0,        18, 1'b1, 32'h0};
        tbl[7] = '{2'b11, 0, 1'b1, 1'b1, 8'hF0, 32'h87654321, 5,  32'h0,        7,  1'b0, 32'h0};

        // Reset state, then a stray ack while idle.
        @(posedge clk); @(posedge clk); #1; #4;
        check_all_zero("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        bus.writeAck = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #4;
            check("stray ack idle", {bus.busy, bus.rsp_valid, bus.writeEnable, bus.readEnable}, 64'd0);
            @(posedge clk); #1;
        end
        bus.writeAck = 1'b0;

        foreach (tbl[k]) begin
            for (int j = 0; j < NR; j++) begin
                if (j == tbl[k].id) set_req(j, tbl[k].w, tbl[k].adm, tbl[k].addr, tbl[k].wd);
                else set_req(j, !tbl[k].w, !tbl[k].adm, ~tbl[k].addr, ~tbl[k].wd);
            end
            txn($sformatf("tbl%0d", k), tbl[k].mask, tbl[k].id, tbl[k].w, tbl[k].adm,
                tbl[k].addr, tbl[k].wd, tbl[k].d, tbl[k].rd, tbl[k].lat, tbl[k].err, tbl[k].exp_rd);
        end

        // Reset during WAIT of a read by requester 1 (pointer is 1 here).
        set_req(0, 1'b1, 1'b0, 8'h40, 32'h11111111);
        set_req(1, 1'b0, 1'b0, 8'h05, 32'h0);
        @(posedge clk); #1;
        bus.req_valid = 2'b10;
        #4;
        check("rw grant", bus.req_ready, 64'b10);
        @(posedge clk); #1;
        bus.req_valid = '0;
        #4;
        check("rw readEnable", bus.readEnable, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        #4;
        check("rw busy in WAIT", bus.busy, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        #4;
        check_all_zero("rw after reset");
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1; #4;
            if (bus.rsp_valid !== '0) seen = 1'b1;
        end
        check("rw no rsp", seen, 0);

        // Both held continuously: grants must alternate starting from requester 0.
        set_req(1, 1'b1, 1'b0, 8'h41, 32'h22222222);
        we_n = 0;
        ovl  = 1'b0;
        bus.writeAck = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 2'b11;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                if (g_ids.size() >= 4) bus.req_valid = '0;
            end
            #4;
            if (bus.req_ready !== '0) begin
                g_ids.push_back(onehot_idx(bus.req_ready));
                g_cyc.push_back(c);
            end
            if (bus.rsp_valid !== '0) r_ids.push_back(onehot_idx(bus.rsp_valid));
            if (bus.writeEnable) we_n++;
            if (bus.writeEnable && bus.readEnable) ovl = 1'b1;
        end
        bus.writeAck = 1'b0;
        gs = 0;
        foreach (g_ids[i]) gs = gs * 10 + g_ids[i] + 1;
        rs = 0;
        foreach (r_ids[i]) rs = rs * 10 + r_ids[i] + 1;
        check("alt grant order", gs, 1212);
        check("alt rsp order", rs, 1212);
        check("alt strobes", we_n, 4);
        check("alt overlap", ovl, 0);
        check("alt spacing", (g_cyc.size() == 4) ? g_cyc[3] - g_cyc[0] : -1, 12);

        // Randomized transactions; requester 1 was served last, so the model pointer is 0.
        mptr = 0;
        for (int n = 0; n < 40; n++) begin
            logic [NR-1:0] mask;
            bit            rw   [NR];
            bit            radm [NR];
            logic [AW-1:0] ra   [NR];
            logic [DW-1:0] rwd  [NR];
            int            id;
            int            d;
            logic [DW-1:0] rd;
            mask = NR'($urandom_range(1, (1 << NR) - 1));
            for (int j = 0; j < NR; j++) begin
                rw[j]   = 1'($urandom);
                radm[j] = 1'($urandom);
                ra[j]   = AW'($urandom);
                rwd[j]  = DW'($urandom);
                set_req(j, rw[j], radm[j], ra[j], rwd[j]);
            end
            id = -1;
            for (int k = 0; k < NR; k++) begin
                if (id < 0 && mask[(mptr + k) % NR]) id = (mptr + k) % NR;
            end
            d  = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, TO + 2));
            rd = DW'($urandom);
            txn($sformatf("rnd%0d", n), mask, id, rw[id], radm[id], ra[id], rwd[id], d, rd,
                model_lat(rw[id], d), model_err(rw[id], d), rw[id] ? '0 : rd);
            mptr = (id + 1) % NR;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
